pc_fetch_ctrl: RTL and testbench

- Sequences the program counter and instruction-memory fetch for the core.
- Issues fetch requests, holds the fetched instruction until the decode stage accepts it, and applies branch/jump redirects.
- Handles exception redirects: external exception, fetch timeout and misaligned target. Saves the EPC and vectors to the exception handler.
- Sits between the instruction-memory port and the decode stage; it owns the architectural PC.

---
 rtl/pc_fetch_pkg.sv | 17 +
 rtl/fetch_timeout_cnt.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [1:0]  EXC_EXT      = 2'b00;
    localparam logic [1:0]  EXC_TIMEOUT  = 2'b01;
    localparam logic [1:0]  EXC_MISALIGN = 2'b10;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Counts cycles a fetch request has been outstanding; expired flags the bus-error limit.
module fetch_timeout_cnt #(
    parameter logic [7:0] TIMEOUT = 8'd8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == TIMEOUT);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Owns the architectural PC: fetches from instruction memory, holds the word for decode,
// and applies branch redirects and exception vectoring.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned TIMEOUT      = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        halt_req,
    output logic        exc_taken,
    output logic [1:0]  exc_cause,
    output logic [31:0] epc,
    output logic        halted
);
    import pc_fetch_pkg::*;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        take_exc, take_redir, misalign, latch_instr;
    logic [1:0]  cause_nx;
    logic [31:0] epc_nx;
    logic        cnt_clr, cnt_inc, expired;

    fetch_timeout_cnt #(.TIMEOUT(8'(TIMEOUT))) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (expired)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
        take_exc    = 1'b0;
        cause_nx    = EXC_EXT;
        epc_nx      = pc;
        state_nx    = state;
        pc_nx       = pc;
        latch_instr = 1'b0;

        // An ack arriving on the expiry cycle still completes the fetch.
        if (exc_req) begin
            take_exc = 1'b1;
        end else if (state == REQ && expired && !imem_ack) begin
            take_exc = 1'b1;
            cause_nx = EXC_TIMEOUT;
        end else if (misalign) begin
            take_exc = 1'b1;
            cause_nx = EXC_MISALIGN;
            epc_nx   = redirect_pc;
        end
        take_redir = redirect_valid && !take_exc;

        if (take_exc) begin
            state_nx = REQ;
            pc_nx    = EXC_VECTOR;
        end else if (take_redir) begin
            state_nx = REQ;
            pc_nx    = redirect_pc;
        end else begin
            case (state)
                BOOT: state_nx = REQ;
                REQ: begin
                    if (imem_ack) begin
                        latch_instr = 1'b1;
                        state_nx    = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_nx    = pc + PC_INCR;
                        state_nx = halt_req ? HALT : REQ;
                    end
                end
                HALT: if (!halt_req) state_nx = REQ;
                default: state_nx = BOOT;
            endcase
        end

        // The timeout window restarts on every fresh entry into REQ.
        cnt_clr = (state != REQ) || (state_nx != REQ) || take_exc || take_redir;
        cnt_inc = !cnt_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc        <= RESET_VECTOR;
            instr     <= '0;
            instr_pc  <= '0;
            exc_taken <= 1'b0;
            exc_cause <= EXC_EXT;
            epc       <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            exc_taken <= take_exc;
            if (latch_instr) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (take_exc) begin
                exc_cause <= cause_nx;
                epc       <= epc_nx;
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl: a per-cycle table plus timeout and reset sequences.
module tb_pc_fetch_ctrl;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        exc;
        logic        halt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_etk;
        logic [1:0]  e_cause;
        logic [31:0] e_epc;
        logic        e_hlt;
    } vec_t;

    localparam logic [31:0] A0 = 32'h1111_0000;
    localparam logic [31:0] A1 = 32'h2222_0004;
    localparam logic [31:0] A2 = 32'h3333_0008;
    localparam logic [31:0] A3 = 32'h4444_0100;
    localparam logic [31:0] A4 = 32'h5555_FFFC;
    localparam logic [31:0] J  = 32'hDEAD_BEEF;
    localparam logic [31:0] WR = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc, epc;
    logic        redirect_valid, exc_req, halt_req, exc_taken, halted;
    logic [1:0]  exc_cause;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .halt_req       (halt_req),
        .exc_taken      (exc_taken),
        .exc_cause      (exc_cause),
        .epc            (epc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [31:0] rdata, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic exc, input logic halt,
                       input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_etk,
                       input logic [1:0] e_cause, input logic [31:0] e_epc, input logic e_hlt);
        vec_t v;
        v = '{ack, rdata, rdy, rv, rpc, exc, halt, e_req, e_addr, e_iv, e_instr, e_ipc,
              e_etk, e_cause, e_epc, e_hlt};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                         input logic rv, input logic [31:0] rpc, input logic exc, input logic halt);
        imem_ack       = ack;
        imem_rdata     = rdata;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exc_req        = exc;
        halt_req       = halt;
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0, 0, 0, 0);

        //   ack rdata rdy rv rpc exc halt | req addr iv instr ipc etk cause epc hlt
        add(0, 0,  0, 0, 0,     0, 0,  0, 0,     0, 0,  0,     0, 0, 0,     0); // BOOT
        add(1, A0, 1, 0, 0,     0, 0,  1, 0,     0, 0,  0,     0, 0, 0,     0); // 1-cycle fetch
        add(0, 0,  1, 0, 0,     0, 0,  0, 0,     1, A0, 0,     0, 0, 0,     0);
        add(1, A1, 0, 0, 0,     0, 0,  1, 4,     0, A0, 0,     0, 0, 0,     0);
        add(0, 0,  1, 0, 0,     0, 0,  0, 4,     1, A1, 4,     0, 0, 0,     0);
        add(1, A2, 0, 0, 0,     0, 0,  1, 8,     0, A1, 4,     0, 0, 0,     0);
        add(0, 0,  0, 0, 0,     0, 0,  0, 8,     1, A2, 8,     0, 0, 0,     0); // 5-cycle stall
        add(0, 0,  0, 0, 0,     0, 0,  0, 8,     1, A2, 8,     0, 0, 0,     0);
        add(1, J,  0, 0, 0,     0, 0,  0, 8,     1, A2, 8,     0, 0, 0,     0);
        add(0, 0,  0, 0, 0,     0, 0,  0, 8,     1, A2, 8,     0, 0, 0,     0);
        add(0, 0,  0, 0, 0,     0, 0,  0, 8,     1, A2, 8,     0, 0, 0,     0);
        add(0, 0,  1, 0, 0,     0, 0,  0, 8,     1, A2, 8,     0, 0, 0,     0);
        add(1, J,  1, 1, 'h100, 0, 0,  1, 'hC,   0, A2, 8,     0, 0, 0,     0); // redirect + ack
        add(0, 0,  0, 0, 0,     0, 0,  1, 'h100, 0, A2, 8,     0, 0, 0,     0);
        add(1, A3, 0, 0, 0,     0, 0,  1, 'h100, 0, A2, 8,     0, 0, 0,     0);
        add(0, 0,  1, 1, 'h200, 1, 0,  0, 'h100, 1, A3, 'h100, 0, 0, 0,     0); // exc beats redirect
        add(0, 0,  0, 0, 0,     0, 0,  1, 'h80,  0, A3, 'h100, 1, 0, 'h100, 0);
        add(0, 0,  0, 1, 'h102, 0, 0,  1, 'h80,  0, A3, 'h100, 0, 0, 'h100, 0); // misaligned
        add(0, 0,  0, 0, 0,     0, 0,  1, 'h80,  0, A3, 'h100, 1, 2, 'h102, 0);
        add(0, 0,  0, 1, WR,    0, 0,  1, 'h80,  0, A3, 'h100, 0, 2, 'h102, 0);
        add(1, A4, 0, 0, 0,     0, 0,  1, WR,    0, A3, 'h100, 0, 2, 'h102, 0);
        add(0, 0,  1, 0, 0,     0, 1,  0, WR,    1, A4, WR,    0, 2, 'h102, 0); // wrap + halt
        add(0, 0,  0, 0, 0,     0, 1,  0, 0,     0, A4, WR,    0, 2, 'h102, 1);
        add(0, 0,  0, 0, 0,     0, 1,  0, 0,     0, A4, WR,    0, 2, 'h102, 1);
        add(0, 0,  0, 0, 0,     0, 0,  0, 0,     0, A4, WR,    0, 2, 'h102, 1);
        add(0, 0,  0, 0, 0,     0, 0,  1, 0,     0, A4, WR,    0, 2, 'h102, 0);

        repeat (3) @(negedge clk);
        check("rst.req",   imem_req,    0);
        check("rst.addr",  imem_addr,   0);
        check("rst.iv",    instr_valid, 0);
        check("rst.instr", instr,       0);
        check("rst.etk",   exc_taken,   0);
        check("rst.epc",   epc,         0);
        check("rst.hlt",   halted,      0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].exc, tbl[i].halt);
            #1;
            check($sformatf("r%0d.req", i),   imem_req,    tbl[i].e_req);
            check($sformatf("r%0d.addr", i),  imem_addr,   tbl[i].e_addr);
            check($sformatf("r%0d.iv", i),    instr_valid, tbl[i].e_iv);
            check($sformatf("r%0d.instr", i), instr,       tbl[i].e_instr);
            check($sformatf("r%0d.ipc", i),   instr_pc,    tbl[i].e_ipc);
            check($sformatf("r%0d.etk", i),   exc_taken,   tbl[i].e_etk);
            check($sformatf("r%0d.cause", i), exc_cause,   tbl[i].e_cause);
            check($sformatf("r%0d.epc", i),   epc,         tbl[i].e_epc);
            check($sformatf("r%0d.hlt", i),   halted,      tbl[i].e_hlt);
            @(negedge clk);
        end

        // Fetch timeout: redirect to 0x40, then never ack.
        drive(0, 0, 0, 1, 'h40, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        n = 0;
        for (int c = 0; c < 40 && !exc_taken; c++) begin
            #1;
            if (imem_req && imem_addr == 'h40) n++;
            @(negedge clk);
        end
        #1;
        check("to.seen",  exc_taken, 1);
        check("to.minwait", (n >= 8 && n <= 9) ? 1 : 0, 1);
        check("to.cause", exc_cause, 2'b01);
        check("to.epc",   epc,       'h40);
        check("to.addr",  imem_addr, 'h80);
        check("to.req",   imem_req,  1);

        // Asynchronous reset in the middle of an outstanding fetch.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar.req",   imem_req,  0);
        check("ar.addr",  imem_addr, 0);
        check("ar.cause", exc_cause, 0);
        check("ar.epc",   epc,       0);
        check("ar.instr", instr,     0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar.boot", imem_req, 0);
        @(negedge clk);
        #1;
        check("ar.req2",  imem_req,  1);
        check("ar.addr2", imem_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
